// File: rtl/hex_scan_display_pkg.sv
// hex_scan_display_pkg
// Shared constants for the multiplexed seven-segment driver:
//   - segment bit indices within the {g,f,e,d,c,b,a} bus
//   - the 16-entry hex glyph table (active-high, abcdefg)
//   - a helper that applies output polarity to a segment pattern
package hex_scan_display_pkg;

    typedef logic [6:0] glyph_t;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Element [n] is the glyph for nibble n (leftmost literal is entry 15).
    localparam logic [15:0][6:0] GLYPHS = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

    localparam glyph_t SEG_ALL_OFF = 7'h00;

    function automatic glyph_t seg_pol(input glyph_t v, input bit active_low);
        return active_low ? ~v : v;
    endfunction

endpackage

// File: rtl/hex_scan_display_if.sv
// hex_scan_display_if
// Bundles the datapath-side controls and the display-pin outputs.
//   master: value, load, blank_lz, dp_mask (and bright) out; seg, dp, an, busy_wrap in
//   slave : the display driver side (directions reversed)
// Optional: HEX_SCAN_BRIGHTNESS_EN adds the 4-bit bright level.
interface hex_scan_display_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic                    load;
    logic                    blank_lz;
    logic [NUM_DIGITS-1:0]   dp_mask;
`ifdef HEX_SCAN_BRIGHTNESS_EN
    logic [3:0]              bright;
`endif
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    busy_wrap;

`ifdef HEX_SCAN_BRIGHTNESS_EN
    modport master (output value, load, blank_lz, dp_mask, bright,
                    input  seg, dp, an, busy_wrap);
    modport slave  (input  value, load, blank_lz, dp_mask, bright,
                    output seg, dp, an, busy_wrap);
`else
    modport master (output value, load, blank_lz, dp_mask,
                    input  seg, dp, an, busy_wrap);
    modport slave  (input  value, load, blank_lz, dp_mask,
                    output seg, dp, an, busy_wrap);
`endif

endinterface

// File: rtl/hex_glyph_rom.sv
// hex_glyph_rom
// Combinational nibble to seven-segment glyph lookup (active-high).
//   nibble : 4-bit hex digit
//   glyph  : {g,f,e,d,c,b,a}
module hex_glyph_rom
    import hex_scan_display_pkg::*;
(
    input  logic [3:0] nibble,
    output glyph_t     glyph
);

    assign glyph = GLYPHS[nibble];

endmodule

// File: rtl/hex_scan_display.sv
// hex_scan_display
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
// A shadow register captures the packed value on load; digits are scanned
// round-robin, SCAN_DIV clocks per digit, with optional leading-zero blanking.
// All outputs come straight from flops.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : hex_scan_display_if.slave
//                value/load/blank_lz/dp_mask in, seg/dp/an/busy_wrap out
// Optional macro HEX_SCAN_BRIGHTNESS_EN: adds bus.bright; an is only asserted
// while the top 4 prescaler bits are below bright (needs SCAN_DIV >= 16).
module hex_scan_display
    import hex_scan_display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1024,
    parameter int ACTIVE_LOW = 1
) (
    input logic              clk,
    input logic              rst_n,
    hex_scan_display_if.slave bus
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRE_TC   = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam bit INV = (ACTIVE_LOW != 0);

    logic [4*NUM_DIGITS-1:0] shadow;
    logic [PW-1:0]           prescaler;
    logic [IW-1:0]           idx;
    logic                    slot_end;

    logic [NUM_DIGITS-1:0]   blanked;
    logic [NUM_DIGITS-1:0]   an_onehot;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic                    an_gate;
    glyph_t                  glyph;

    glyph_t                  seg_q;
    logic                    dp_q;
    logic [NUM_DIGITS-1:0]   an_q;
    logic                    busy_wrap_q;

    assign slot_end = (prescaler == PRE_TC);

    // Walk from the most significant digit down; a digit is a leading zero
    // while every nibble above and including it is zero. Digit 0 always shows.
    always_comb begin
        logic run;
        run     = 1'b1;
        blanked = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run = run & (shadow[4*i +: 4] == 4'h0);
            blanked[i] = bus.blank_lz & run & (i != 0);
        end
    end

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        an_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib      = shadow[4*i +: 4];
                cur_dp       = bus.dp_mask[i];
                cur_blank    = blanked[i];
                an_onehot[i] = 1'b1;
            end
        end
    end

`ifdef HEX_SCAN_BRIGHTNESS_EN
    assign an_gate = (prescaler[PW-1 -: 4] < bus.bright);
`else
    assign an_gate = 1'b1;
`endif

    hex_glyph_rom u_rom (
        .nibble (cur_nib),
        .glyph  (glyph)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow      <= '0;
            prescaler   <= '0;
            idx         <= '0;
            busy_wrap_q <= 1'b0;
            seg_q       <= {7{INV}};
            dp_q        <= INV;
            an_q        <= {NUM_DIGITS{INV}};
        end else begin
            if (bus.load) begin
                shadow <= bus.value;
            end
            if (slot_end) begin
                prescaler <= '0;
                idx       <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
            // Set on the same edge that returns idx to 0, so the pulse
            // occupies the first cycle with idx back at digit 0.
            busy_wrap_q <= slot_end && (idx == IDX_LAST);
            an_q        <= (an_gate ? an_onehot : '0) ^ {NUM_DIGITS{INV}};
            seg_q       <= seg_pol(cur_blank ? SEG_ALL_OFF : glyph, INV);
            dp_q        <= cur_dp ^ INV;
        end
    end

    assign bus.seg       = seg_q;
    assign bus.dp        = dp_q;
    assign bus.an        = an_q;
    assign bus.busy_wrap = busy_wrap_q;

endmodule

// File: tb/tb_hex_scan_display.sv
// tb_hex_scan_display
// Directed bench for hex_scan_display with NUM_DIGITS=4, SCAN_DIV=4,
// ACTIVE_LOW=1. Each digit is shown for 4 clocks; a full scan is 16 clocks.
module tb_hex_scan_display;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    hex_scan_display_if #(.NUM_DIGITS(4)) bus ();

    hex_scan_display #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (4),
        .ACTIVE_LOW (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inverted glyphs (active-low outputs)
    localparam logic [6:0] S0   = 7'h40;
    localparam logic [6:0] S1   = 7'h79;
    localparam logic [6:0] S2   = 7'h24;
    localparam logic [6:0] S3   = 7'h30;
    localparam logic [6:0] SA   = 7'h08;
    localparam logic [6:0] SF   = 7'h0E;
    localparam logic [6:0] SOFF = 7'h7F;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered just after the edge that first shows digit 0; exits at the
    // same phase one scan later.
    task automatic scan_check(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3, input logic [3:0] edp);
        logic [6:0] es [4];
        logic [3:0] ean;
        es[0] = e0; es[1] = e1; es[2] = e2; es[3] = e3;
        for (int d = 0; d < 4; d++) begin
            ean = 4'b0001 << d;
            ean = ~ean;
            chk($sformatf("%s an d%0d", tag, d), 32'(bus.an), 32'(ean));
            chk($sformatf("%s seg d%0d", tag, d), 32'(bus.seg), 32'(es[d]));
            chk($sformatf("%s dp d%0d", tag, d), 32'(bus.dp), 32'(edp[d]));
            tick(4);
        end
    endtask

    // Load at scan phase 1, returns at scan phase 1 of the next scan.
    task automatic do_load(input logic [15:0] v);
        bus.value = v;
        bus.load  = 1'b1;
        tick(1);
        bus.load  = 1'b0;
        tick(15);
    endtask

`ifdef HEX_SCAN_BRIGHTNESS_EN
    initial bus.bright = 4'hF;
`endif

    initial begin
        rst_n        = 1'b1;
        bus.value    = 16'h0;
        bus.load     = 1'b0;
        bus.blank_lz = 1'b0;
        bus.dp_mask  = 4'b0000;
        #2 rst_n = 1'b0;
        #1;
        chk("rst seg", 32'(bus.seg), 32'(SOFF));
        chk("rst an", 32'(bus.an), 32'hF);
        chk("rst dp", 32'(bus.dp), 32'h1);
        chk("rst busy_wrap", 32'(bus.busy_wrap), 32'h0);

        @(negedge clk) rst_n = 1'b1;
        tick(1);
        scan_check("idle", S0, S0, S0, S0, 4'b1111);

        tick(15);
        chk("wrap pulse", 32'(bus.busy_wrap), 32'h1);
        chk("wrap an d3", 32'(bus.an), 32'h7);
        tick(1);
        chk("wrap clear", 32'(bus.busy_wrap), 32'h0);
        chk("wrap an d0", 32'(bus.an), 32'hE);

        // Load latency: glyph changes two edges after load is sampled
        bus.dp_mask = 4'b0101;
        bus.value   = 16'h12AF;
        bus.load    = 1'b1;
        tick(1);
        bus.load    = 1'b0;
        chk("load lat old", 32'(bus.seg), 32'(S0));
        tick(1);
        chk("load lat new", 32'(bus.seg), 32'(SF));
        tick(14);
        scan_check("12AF", SF, SA, S2, S1, 4'b1010);

        bus.dp_mask  = 4'b0000;
        bus.blank_lz = 1'b1;
        do_load(16'h0030);
        scan_check("lz 0030", S0, S3, SOFF, SOFF, 4'b1111);
        do_load(16'h0000);
        scan_check("lz 0000", S0, SOFF, SOFF, SOFF, 4'b1111);

        // Load coincident with the terminal count that leaves digit 2
        bus.blank_lz = 1'b0;
        do_load(16'h1111);
        tick(10);
        chk("tc d2 an", 32'(bus.an), 32'hB);
        chk("tc d2 seg old", 32'(bus.seg), 32'(S1));
        bus.value = 16'h2222;
        bus.load  = 1'b1;
        tick(1);
        bus.load  = 1'b0;
        chk("tc d2 still old", 32'(bus.seg), 32'(S1));
        tick(1);
        chk("tc d3 an", 32'(bus.an), 32'h7);
        chk("tc d3 seg new", 32'(bus.seg), 32'(S2));
        tick(4);
        chk("tc next d0 an", 32'(bus.an), 32'hE);
        chk("tc next d0 seg", 32'(bus.seg), 32'(S2));

        // Asynchronous reset mid-slot
        bus.dp_mask = 4'b1111;
        tick(2);
        chk("pre-rst dp", 32'(bus.dp), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("async seg", 32'(bus.seg), 32'(SOFF));
        chk("async an", 32'(bus.an), 32'hF);
        chk("async dp", 32'(bus.dp), 32'h1);
        @(negedge clk) rst_n = 1'b1;
        bus.dp_mask = 4'b0000;
        tick(1);
        chk("post-rst an", 32'(bus.an), 32'hE);
        chk("post-rst seg", 32'(bus.seg), 32'(S0));
        chk("post-rst busy_wrap", 32'(bus.busy_wrap), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hex_scan_display.md
Name: hex_scan_display

Overview:
Time-multiplexed driver for a bank of common-anode seven-segment digits. It is the multi-digit, parametrised successor of the single-digit hex-to-segment decoder.
- Latches a packed hex value into a shadow register on a load strobe.
- Scans the digits round-robin at a divided rate, driving one anode at a time with the registered glyph for that digit.
- Supports leading-zero blanking.
- Sits between the debug/status datapath and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
SCAN_DIV, 1024, clocks per digit slot (>=2; prescaler width = clog2(SCAN_DIV))
ACTIVE_LOW, 1, 1 = segment and anode outputs active-low; 0 = active-high

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
value  in  4*NUM_DIGITS  packed nibbles; [3:0] = digit 0 (least significant, rightmost)
load  in  1  single-cycle strobe; captures value into shadow register
blank_lz  in  1  level; 1 = enable leading-zero blanking
dp_mask  in  NUM_DIGITS  decimal-point enable per digit, sampled live
seg  out  7  segments, bit order {g,f,e,d,c,b,a}
dp  out  1  decimal point for the active digit
an  out  NUM_DIGITS  one-hot digit enable
busy_wrap  out  1  one-cycle pulse when the scan index wraps from NUM_DIGITS-1 to 0

Behaviour:
- Clock and reset: single clock domain clk. Reset is asynchronous and active-low on rst_n.
- Reset values (all inactive):
  - shadow = 0, prescaler = 0, idx = 0, busy_wrap = 0.
  - seg, dp and an are all inactive: all ones when ACTIVE_LOW=1, all zeros otherwise.
- Load:
  - When load=1 at an edge, shadow <= value.
  - Any load while idle or mid-slot is legal.
  - The new glyph appears on the outputs one cycle after the shadow update (2 edges after load sampled).
- Prescaler:
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - At terminal count (SCAN_DIV-1), idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1.
  - busy_wrap is registered high for exactly the cycle after idx transitions NUM_DIGITS-1 -> 0.
- Output stage (registered, 1-cycle latency from idx/shadow):
  - an: bit idx active, all others inactive.
  - seg = glyph(shadow nibble idx), unless that digit is blanked.
  - dp = dp_mask[idx].
- Glyphs (abcdefg hex, active-high before polarity):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Polarity: when ACTIVE_LOW=1, seg, dp and an are inverted at the flop inputs. No combinational path reaches any output.
- Leading-zero blanking:
  - Digit i is blanked when blank_lz=1 and every nibble from NUM_DIGITS-1 down to i is zero.
  - Digit 0 is never blanked, so value 0 displays a single "0".
  - A blanked digit drives all segments inactive; an is still asserted and dp still follows dp_mask.
  - Blanking is evaluated from the shadow register, never from the value input.
- Simultaneous events:
  - load coincident with terminal count: idx advances and shadow updates on the same edge. The next digit shows the new value.
  - blank_lz and dp_mask changes take effect on the next output flop update.
- NUM_DIGITS=1: idx stays 0. busy_wrap pulses once per slot.
- Reset asserted mid-scan: all outputs go inactive immediately (asynchronous). After release, scanning restarts at digit 0 with prescaler 0.

Optional Feature:
HEX_SCAN_BRIGHTNESS_EN
- With the macro defined:
  - Adds input bright [3:0].
  - Within each slot, an is asserted only while prescaler[MSB-:4] < bright. bright=0 turns the display off; bright=15 gives a 15/16 duty cycle.
  - seg and dp are unaffected.
  - Requires SCAN_DIV >= 16.
- Without the macro: the bright port is absent and an stays asserted for the full slot.

Decomposition:
- Shared package/header: the 16-entry glyph constant table, segment bit-index localparams (SEG_A..SEG_G), and the polarity helper constant.
- One sub-module, hex_glyph_rom: combinational nibble -> 7-bit active-high glyph. It is instantiated once and muxed by idx.
- Prescaler, idx, blanking and the output flops stay in the top module.

Test Plan:
- Reset then release with NUM_DIGITS=4, SCAN_DIV=4, no load -> an cycles 1110,1101,1011,0111 (ACTIVE_LOW); seg=7'b1000000 (glyph 0 inverted) on every digit; busy_wrap pulses every 16 clocks.
- load value=16'h12AF, blank_lz=0 -> over one scan, seg (inverted) shows F,A,2,1 on digits 0..3.
- value=16'h0030, blank_lz=1 -> digits 3 and 2 all segments off with an asserted; digit 1 shows 3, digit 0 shows 0. Then value=0 -> only digit 0 lit, showing 0.
- load asserted on the terminal-count edge of digit 2 -> digit 3 displays the new nibble in that same scan; digits 0..2 display new nibbles only on the following scan.
- rst_n pulsed low mid-slot -> seg, dp and an go inactive without waiting for a clk edge; after release, the first active an is digit 0 and busy_wrap is 0.
- HEX_SCAN_BRIGHTNESS_EN defined, SCAN_DIV=64, bright=4 -> an asserted for 16 of 64 clocks per slot; bright=0 -> an never asserted.
